lc3_mem_responder: RTL and testbench

- Memory-side responder for the LC-3 datapath's MAR/MDR memory interface.
- Accepts one read or write request at a time from the control/datapath side when MIO_EN is asserted.
- Inserts a fixed number of wait states, performs the access on an internal word array, and returns a one-cycle R (ready) pulse.
- The control FSM holds its memory state until it samples R=1.

---
 rtl/lc3_mem_responder_if.sv | 22 ++
 rtl/lc3_mem_responder.sv | 108 ++++++++++
 tb/tb_lc3_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_responder_if.sv
// Memory request/response bundle between the LC-3 control/datapath and the memory responder.
// Handshake: a request is taken when MIO_EN=1 in IDLE; R pulses once on completion.
`timescale 1ns/1ps
interface lc3_mem_responder_if;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] MAR;
    logic [15:0] MDR_IN;
    logic [15:0] MEM_OUT;
    logic        R;
    logic        ERR;

    modport slave (
        input  MIO_EN, R_W, MAR, MDR_IN,
        output MEM_OUT, R, ERR
    );

    modport master (
        output MIO_EN, R_W, MAR, MDR_IN,
        input  MEM_OUT, R, ERR
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: captures one MAR/MDR request, waits WAIT_CYCLES,
// accesses the word array and pulses R (with ERR for out-of-range MAR) for one cycle.
`timescale 1ns/1ps
module lc3_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    lc3_mem_responder_if.slave      bus,
    output logic [1:0]              o_dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [15:0]     r_mar;
    logic [15:0]     r_mdr;
    logic            r_rw;
    logic [15:0]     r_mem_out;
    logic            r_err;
    logic [15:0]     r_mem [DEPTH];

    logic            w_capture;
    logic            w_access;
    logic            w_in_range;
    logic [AW-1:0]   w_idx;

    // Widened compare so DEPTH=65536 still fits and every MAR is in range.
    assign w_in_range = ({1'b0, r_mar} < 17'(DEPTH));
    assign w_idx      = r_mar[AW-1:0];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        w_access   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.MIO_EN) begin
                    w_capture  = 1'b1;
                    w_cnt_next = CW'(WAIT_CYCLES - 1);
                    w_next     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_access = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_rw      <= 1'b0;
            r_mem_out <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_mar <= bus.MAR;
                r_mdr <= bus.MDR_IN;
                r_rw  <= bus.R_W;
            end
            if (w_access && !r_rw) begin
                r_mem_out <= w_in_range ? r_mem[w_idx] : 16'h0000;
            end
            // Only the access edge can raise ERR, so it is high exactly in DONE.
            r_err <= w_access && !w_in_range;
        end
    end

    // Array contents survive reset; a reset before the access edge drops the write.
    always_ff @(posedge CLK) begin
        if (w_access && r_rw && w_in_range) begin
            r_mem[w_idx] <= r_mdr;
        end
    end

    assign bus.MEM_OUT  = r_mem_out;
    assign bus.R        = (r_state == S_DONE);
    assign bus.ERR      = r_err;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: default build (WAIT_CYCLES=4) with a
// scoreboard of {ERR, MEM_OUT} per completed access, plus a WAIT_CYCLES=1 build.
`timescale 1ns/1ps
module tb_lc3_mem_responder;
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    lc3_mem_responder_if bus0 ();
    lc3_mem_responder_if bus1 ();
    logic [1:0] dbg0;
    logic [1:0] dbg1;

    lc3_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(4)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus0), .o_dbg_state(dbg0)
    );
    lc3_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .bus(bus1), .o_dbg_state(dbg1)
    );

    int total = 0;
    int bad = 0;
    int r_pulses = 0;
    logic [16:0] exp_q[$];
    logic [16:0] sb_e;
    logic [15:0] model_mem [0:1023];
    logic [15:0] exp_out = 16'h0000;

    // Scoreboard monitor: every R cycle of dut0 is matched against the queue.
    always @(posedge CLK) begin
        #1;
        if (RST_N) begin
            total++;
            if (bus0.ERR && !bus0.R) begin
                bad++;
                $display("FAIL err_without_r: ERR=%0b R=%0b, ERR must only be high with R", bus0.ERR, bus0.R);
            end
            if (bus0.R) begin
                r_pulses++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_r: R=1 with no access outstanding");
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({bus0.ERR, bus0.MEM_OUT} !== sb_e) begin
                        bad++;
                        $display("FAIL sb_data: got err=%0b mem_out=%h, want err=%0b mem_out=%h",
                                 bus0.ERR, bus0.MEM_OUT, sb_e[16], sb_e[15:0]);
                    end
                end
            end
        end
    end

    task automatic sb_push(input logic rw, input logic [15:0] addr, input logic [15:0] data);
        if (addr < 16'd1024) begin
            if (rw) begin
                model_mem[addr[9:0]] = data;
            end else begin
                exp_out = model_mem[addr[9:0]];
            end
            exp_q.push_back({1'b0, exp_out});
        end else begin
            if (!rw) exp_out = 16'h0000;
            exp_q.push_back({1'b1, exp_out});
        end
    endtask

    // Drives one request into IDLE; returns at the negedge after the accepting edge.
    task automatic req0(input logic rw, input logic [15:0] addr, input logic [15:0] data, input bit push);
        @(negedge CLK);
        bus0.MIO_EN = 1'b1;
        bus0.R_W    = rw;
        bus0.MAR    = addr;
        bus0.MDR_IN = data;
        if (push) sb_push(rw, addr, data);
        @(posedge CLK);
        @(negedge CLK);
        bus0.MIO_EN = 1'b0;
    endtask

    // Counts rising edges until R is seen; -1 when the budget runs out.
    task automatic wait_r0(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK);
            #1;
            if (bus0.R) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus0.MIO_EN = 1'b0; bus0.R_W = 1'b0; bus0.MAR = '0; bus0.MDR_IN = '0;
        bus1.MIO_EN = 1'b0; bus1.R_W = 1'b0; bus1.MAR = '0; bus1.MDR_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if ({bus0.R, bus0.ERR, bus0.MEM_OUT, dbg0} !== {1'b0, 1'b0, 16'h0000, 2'd0}) begin
            bad++;
            $display("FAIL reset_dut0: got R=%0b ERR=%0b MEM_OUT=%h st=%0d, want 0 0 0000 0",
                     bus0.R, bus0.ERR, bus0.MEM_OUT, dbg0);
        end
        total++;
        if ({bus1.R, bus1.ERR, bus1.MEM_OUT} !== 18'h0) begin
            bad++;
            $display("FAIL reset_dut1: got R=%0b ERR=%0b MEM_OUT=%h, want 0 0 0000",
                     bus1.R, bus1.ERR, bus1.MEM_OUT);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_write_read();
        int lat;
        req0(1'b1, 16'h0010, 16'hBEEF, 1'b1);
        wait_r0(lat);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL wr_latency: got %0d edges, want 4", lat); end
        @(posedge CLK); #1;
        total++;
        if (bus0.R !== 1'b0) begin bad++; $display("FAIL wr_r_one_cycle: R=%0b after DONE, want 0", bus0.R); end
        req0(1'b0, 16'h0010, 16'h0000, 1'b1);
        wait_r0(lat);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL rd_latency: got %0d edges, want 4", lat); end
        @(posedge CLK); #1;
        total++;
        if (bus0.MEM_OUT !== 16'hBEEF) begin bad++; $display("FAIL rd_hold: MEM_OUT=%h, want beef", bus0.MEM_OUT); end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [15:0] addr [4];
        logic        rw   [4];
        logic [15:0] data [4];
        addr = '{16'h0000, 16'h3000, 16'h3000, 16'h0000};
        rw   = '{1'b1, 1'b0, 1'b1, 1'b0};
        data = '{16'h7777, 16'h0000, 16'h1234, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            req0(rw[i], addr[i], data[i], 1'b1);
            wait_r0(lat);
            total++;
            if (lat !== 4) begin bad++; $display("FAIL oor_latency[%0d]: got %0d edges, want 4", i, lat); end
            @(posedge CLK); #1;
            total++;
            if ({bus0.R, bus0.ERR} !== 2'b00) begin
                bad++;
                $display("FAIL oor_clear[%0d]: R=%0b ERR=%0b after DONE, want 0 0", i, bus0.R, bus0.ERR);
            end
        end
    endtask

    task automatic test_wait_ignores_inputs();
        int lat;
        int p;
        req0(1'b1, 16'h0009, 16'h9999, 1'b1);
        wait_r0(lat);
        @(posedge CLK);
        req0(1'b1, 16'h0005, 16'hAAAA, 1'b1);
        p = r_pulses;
        bus0.MIO_EN = 1'b1; bus0.R_W = 1'b0; bus0.MAR = 16'h0009; bus0.MDR_IN = 16'h0BAD;
        wait_r0(lat);
        bus0.MIO_EN = 1'b0;
        total++;
        if (lat !== 4) begin bad++; $display("FAIL ign_latency: got %0d edges, want 4", lat); end
        repeat (8) @(posedge CLK);
        #1;
        total++;
        if (r_pulses - p !== 1) begin bad++; $display("FAIL ign_pulses: got %0d R pulses, want 1", r_pulses - p); end
        req0(1'b0, 16'h0005, 16'h0000, 1'b1);
        wait_r0(lat);
        @(posedge CLK);
        req0(1'b0, 16'h0009, 16'h0000, 1'b1);
        wait_r0(lat);
        @(posedge CLK);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic        rw   [4];
        logic [15:0] addr [4];
        logic [15:0] data [4];
        rw   = '{1'b1, 1'b0, 1'b1, 1'b0};
        addr = '{16'h0040, 16'h0040, 16'h0041, 16'h0041};
        data = '{16'h0001, 16'h0000, 16'h0002, 16'h0000};
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            bus0.MIO_EN = 1'b1; bus0.R_W = rw[i]; bus0.MAR = addr[i]; bus0.MDR_IN = data[i];
            sb_push(rw[i], addr[i], data[i]);
            wait_r0(lat);
            total++;
            if (lat !== ((i == 0) ? 5 : 6)) begin
                bad++;
                $display("FAIL b2b_spacing[%0d]: got %0d edges, want %0d", i, lat, (i == 0) ? 5 : 6);
            end
        end
        bus0.MIO_EN = 1'b0;
        @(posedge CLK); #1;
        total++;
        if (bus0.MEM_OUT !== 16'h0002) begin bad++; $display("FAIL b2b_last_read: MEM_OUT=%h, want 0002", bus0.MEM_OUT); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int p;
        req0(1'b1, 16'h0020, 16'h1111, 1'b1);
        wait_r0(lat);
        @(posedge CLK);
        req0(1'b0, 16'h0020, 16'h0000, 1'b1);
        wait_r0(lat);
        @(posedge CLK);
        req0(1'b1, 16'h0020, 16'h5555, 1'b0);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        total++;
        if ({bus0.R, bus0.MEM_OUT, dbg0} !== {1'b0, 16'h0000, 2'd0}) begin
            bad++;
            $display("FAIL mid_reset: got R=%0b MEM_OUT=%h st=%0d, want 0 0000 0", bus0.R, bus0.MEM_OUT, dbg0);
        end
        p = r_pulses;
        @(negedge CLK);
        RST_N = 1'b1;
        exp_out = 16'h0000;
        repeat (8) @(posedge CLK);
        #1;
        total++;
        if (r_pulses !== p) begin bad++; $display("FAIL mid_reset_no_r: got %0d R pulses, want 0", r_pulses - p); end
        req0(1'b0, 16'h0020, 16'h0000, 1'b1);
        wait_r0(lat);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL mid_reset_read_latency: got %0d edges, want 4", lat); end
        @(posedge CLK);
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] a;
        logic [15:0] d;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom_range(0, 1023));
            d = 16'($urandom_range(0, 65535));
            req0(1'b1, a, d, 1'b1);
            wait_r0(lat);
            @(posedge CLK);
            req0(1'b0, a, 16'h0000, 1'b1);
            wait_r0(lat);
            total++;
            if (lat !== 4) begin bad++; $display("FAIL rand_latency[%0d]: got %0d edges, want 4", i, lat); end
            @(posedge CLK);
        end
    endtask

    task automatic test_wait1_build();
        logic        rw   [3];
        logic [15:0] addr [3];
        logic [15:0] data [3];
        logic [17:0] want [3];
        rw   = '{1'b1, 1'b0, 1'b0};
        addr = '{16'h03FF, 16'h03FF, 16'h0400};
        data = '{16'hC3C3, 16'h0000, 16'h0000};
        want = '{{1'b1, 1'b0, 16'h0000}, {1'b1, 1'b0, 16'hC3C3}, {1'b1, 1'b1, 16'h0000}};
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus1.MIO_EN = 1'b1; bus1.R_W = rw[i]; bus1.MAR = addr[i]; bus1.MDR_IN = data[i];
            @(posedge CLK);
            @(negedge CLK);
            bus1.MIO_EN = 1'b0;
            total++;
            if (bus1.R !== 1'b0) begin bad++; $display("FAIL w1_early_r[%0d]: R=%0b in WAIT, want 0", i, bus1.R); end
            @(posedge CLK); #1;
            total++;
            if ({bus1.R, bus1.ERR, bus1.MEM_OUT} !== want[i]) begin
                bad++;
                $display("FAIL w1_resp[%0d]: got R=%0b ERR=%0b MEM_OUT=%h, want R=%0b ERR=%0b MEM_OUT=%h",
                         i, bus1.R, bus1.ERR, bus1.MEM_OUT, want[i][17], want[i][16], want[i][15:0]);
            end
            @(posedge CLK); #1;
            total++;
            if ({bus1.R, bus1.ERR} !== 2'b00) begin
                bad++;
                $display("FAIL w1_clear[%0d]: R=%0b ERR=%0b, want 0 0", i, bus1.R, bus1.ERR);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_wait_ignores_inputs();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        test_wait1_build();
        repeat (4) @(posedge CLK);
        #1;
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d accesses never completed, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
